// File: rtl/expr_pkg.sv
// Shared types and helpers for the expression stimulus/capture engine.
// Field k is 4+(k mod 3) bits wide and is signed when (k mod 6) >= 3.
package expr_pkg;

  localparam int Y_W        = 90;
  localparam int OPND_W     = 60;
  localparam int NUM_FIELDS = 18;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CAPTURE,
    S_UNPACK,
    S_NEXT,
    S_DONE
  } state_t;

  // Every group of three fields spans 15 bits, packed from the MSB down.
  function automatic logic [5:0] field_ext(
    input logic [Y_W-1:0] y,
    input logic [4:0]     k
  );
    logic [4:0]     grp;
    logic [4:0]     m3;
    logic [4:0]     m6;
    logic [6:0]     base;
    logic [6:0]     lsb;
    logic [Y_W-1:0] sh;
    logic [5:0]     raw;
    logic           sgn;
    logic [5:0]     f;
    grp = k / 5'd3;
    m3  = k % 5'd3;
    m6  = k % 5'd6;
    case (m3)
      5'd0:    base = 7'd86;
      5'd1:    base = 7'd81;
      default: base = 7'd75;
    endcase
    lsb = base - ({2'b00, grp} * 7'd15);
    sh  = y >> lsb;
    raw = sh[5:0];
    sgn = (m6 >= 5'd3);
    case (m3)
      5'd0:    f = {{2{sgn & raw[3]}}, raw[3:0]};
      5'd1:    f = {sgn & raw[4], raw[4:0]};
      default: f = raw;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/expr_misr32.sv
// 32-bit MISR folding one 6-bit field per enabled cycle.
// Reset and clear both return the signature to all ones.
module expr_misr32
  import expr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [5:0]  din,
  output logic [31:0] sig
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sig <= '1;
    end else if (en) begin
      sig <= {sig[30:0], 1'b0}
           ^ (sig[31] ? MISR_POLY : 32'd0)
           ^ {26'd0, din};
    end
  end

endmodule

// File: rtl/expr_stim_capture.sv
// Drives LFSR operands, captures the packed result bus after a settle
// window and streams its normalised fields into a MISR signature.
module expr_stim_capture
  import expr_pkg::*;
#(
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [63:0] LFSR_SEED     = 64'hACE1_2468_1357_BDF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [OPND_W-1:0] opnd,
  input  logic [Y_W-1:0]    y_in,
  output logic              field_valid,
  input  logic              field_ready,
  output logic [4:0]        field_idx,
  output logic [5:0]        field_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       signature,
  output logic [15:0]       vec_count
);

  localparam logic [63:0] SEED =
    (LFSR_SEED == 64'd0) ? 64'd1 : LFSR_SEED;
  localparam logic [16:0] NV = 17'(NUM_VECTORS);
  localparam int CW =
    (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(SETTLE_CYCLES);
  localparam logic [4:0] LAST = 5'(NUM_FIELDS - 1);

  state_t         state;
  state_t         state_n;
  logic [63:0]    lfsr;
  logic [63:0]    lfsr_n;
  logic [Y_W-1:0] y_q;
  logic [CW-1:0]  cnt;
  logic [16:0]    vc_inc;
  logic           go;
  logic           accept;
  logic           last;

  assign go          = start & ((state == S_IDLE) | (state == S_DONE));
  assign field_valid = (state == S_UNPACK);
  assign field_data  = field_ext(y_q, field_idx);
  assign accept      = field_valid & field_ready;
  assign last        = (field_idx == LAST);
  assign vc_inc      = {1'b0, vec_count} + 17'd1;
  assign lfsr_n      = {1'b0, lfsr[63:1]}
                     ^ (lfsr[0] ? LFSR_TAPS : 64'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE,
      S_DONE:    if (start) state_n = S_DRIVE;
      S_DRIVE:   state_n = S_SETTLE;
      S_SETTLE:  if (cnt <= CW'(1)) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_UNPACK;
      S_UNPACK:  if (accept && last) state_n = S_NEXT;
      S_NEXT:    state_n = (vc_inc == NV) ? S_DONE : S_DRIVE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opnd      <= '0;
      lfsr      <= '0;
      y_q       <= '0;
      cnt       <= '0;
      field_idx <= '0;
      vec_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr      <= SEED;
            vec_count <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_DRIVE: begin
          opnd <= lfsr[63:4];
          lfsr <= lfsr_n;
          cnt  <= SC;
        end
        S_SETTLE: cnt <= cnt - CW'(1);
        S_CAPTURE: begin
          y_q       <= y_in;
          field_idx <= '0;
        end
        S_UNPACK: begin
          if (accept && !last) field_idx <= field_idx + 5'd1;
        end
        S_NEXT: begin
          if (vec_count != 16'hFFFF) vec_count <= vc_inc[15:0];
          if (vc_inc == NV) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  expr_misr32 u_misr (
    .clk   (clk),
    .reset (reset),
    .clear (go),
    .en    (accept),
    .din   (field_data),
    .sig   (signature)
  );

endmodule
